// File: rtl/gshare_predictor.sv
// Gshare branch predictor: PC-xor-history indexed table of saturating counters
// with resolve-time training and saturating branch/mispredict statistics.
module gshare_predictor #(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned HIST_W  = 4,
    parameter int unsigned STAT_W  = 16,
    localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       lookup_pc_i,
    output logic              predict_o,
    output logic [IDX_W-1:0]  predict_idx_o,
    input  logic              update_i,
    input  logic [IDX_W-1:0]  update_idx_i,
    input  logic              update_pred_i,
    input  logic              result_i,
    output logic [STAT_W-1:0] stat_branches_o,
    output logic [STAT_W-1:0] stat_mispred_o
);

    // Bimodal mode keeps a 1-bit dummy history that is held at zero.
    localparam int unsigned GHR_W = (HIST_W > 0) ? HIST_W : 1;
    localparam logic [CTR_W-1:0]  CTR_RST  = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0]  CTR_MAX  = '1;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic [CTR_W-1:0]  ctr_q [ENTRIES];
    logic [CTR_W-1:0]  ctr_d [ENTRIES];
    logic [GHR_W-1:0]  ghr_q, ghr_d;
    logic [STAT_W-1:0] branches_q, branches_d;
    logic [STAT_W-1:0] mispred_q, mispred_d;
    logic [IDX_W-1:0]  hist_idx;
    logic [IDX_W-1:0]  lookup_idx;
    logic              unused_pc;

    assign unused_pc = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0]};

    // Lookup path: combinational from current (pre-edge) state, no bypass.
    always_comb begin
        hist_idx = '0;
        if (HIST_W > 0) begin
            hist_idx = IDX_W'(ghr_q);
        end
        lookup_idx = lookup_pc_i[IDX_W+1:2] ^ hist_idx;
    end

    assign predict_idx_o   = lookup_idx;
    assign predict_o       = ctr_q[lookup_idx][CTR_W-1];
    assign stat_branches_o = branches_q;
    assign stat_mispred_o  = mispred_q;

    // Training and statistics for a resolved branch.
    always_comb begin
        ctr_d      = ctr_q;
        ghr_d      = ghr_q;
        branches_d = branches_q;
        mispred_d  = mispred_q;
        if (update_i) begin
            if (result_i) begin
                if (ctr_q[update_idx_i] != CTR_MAX) begin
                    ctr_d[update_idx_i] = ctr_q[update_idx_i] + CTR_W'(1);
                end
            end else if (ctr_q[update_idx_i] != '0) begin
                ctr_d[update_idx_i] = ctr_q[update_idx_i] - CTR_W'(1);
            end
            if (HIST_W > 0) begin
                ghr_d = GHR_W'({ghr_q, result_i});
            end
            if (branches_q != STAT_MAX) begin
                branches_d = branches_q + STAT_W'(1);
            end
            if ((update_pred_i != result_i) && (mispred_q != STAT_MAX)) begin
                mispred_d = mispred_q + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr_q[i] <= CTR_RST;
            end
            ghr_q      <= '0;
            branches_q <= '0;
            mispred_q  <= '0;
        end else begin
            ctr_q      <= ctr_d;
            ghr_q      <= ghr_d;
            branches_q <= branches_d;
            mispred_q  <= mispred_d;
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: a bimodal 16-entry instance (4-bit stats) and a
// default gshare instance, both checked against an array-based reference model.
module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        rst, upd, upd_pred, res;
    logic [31:0] pc;
    logic [3:0]  uia;
    logic [5:0]  uib;
    logic        pa, pb;
    logic [3:0]  ia, bra, mpa;
    logic [5:0]  ib;
    logic [15:0] brb, mpb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gshare_predictor #(.ENTRIES(16), .CTR_W(2), .HIST_W(0), .STAT_W(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .lookup_pc_i(pc), .predict_o(pa), .predict_idx_o(ia),
        .update_i(upd), .update_idx_i(uia), .update_pred_i(upd_pred), .result_i(res),
        .stat_branches_o(bra), .stat_mispred_o(mpa));

    gshare_predictor #(.ENTRIES(64), .CTR_W(2), .HIST_W(4), .STAT_W(16)) dut_b (
        .clk_i(clk), .rst_i(rst), .lookup_pc_i(pc), .predict_o(pb), .predict_idx_o(ib),
        .update_i(upd), .update_idx_i(uib), .update_pred_i(upd_pred), .result_i(res),
        .stat_branches_o(brb), .stat_mispred_o(mpb));

    // Reference model: index 0 = bimodal instance, index 1 = gshare instance.
    int m_ctr [2][64];
    int m_ghr [2];
    int m_br  [2];
    int m_mp  [2];

    function automatic int ent(int m);  return (m == 0) ? 16 : 64;    endfunction
    function automatic int hist(int m); return (m == 0) ? 0 : 4;      endfunction
    function automatic int smax(int m); return (m == 0) ? 15 : 65535; endfunction

    function automatic int m_idx(int m, logic [31:0] p);
        int base;
        base = int'(p[11:2]) % ent(m);
        return (hist(m) == 0) ? base : (base ^ m_ghr[m]);
    endfunction

    function automatic logic m_pred(int m, logic [31:0] p);
        return m_ctr[m][m_idx(m, p)] >= 2;
    endfunction

    task automatic m_reset();
        for (int m = 0; m < 2; m++) begin
            for (int e = 0; e < 64; e++) m_ctr[m][e] = 1;
            m_ghr[m] = 0; m_br[m] = 0; m_mp[m] = 0;
        end
    endtask

    task automatic m_update(int m, int idx, logic pr, logic rs);
        if (rs) m_ctr[m][idx] = (m_ctr[m][idx] < 3) ? m_ctr[m][idx] + 1 : 3;
        else    m_ctr[m][idx] = (m_ctr[m][idx] > 0) ? m_ctr[m][idx] - 1 : 0;
        if (hist(m) > 0) m_ghr[m] = ((m_ghr[m] * 2) + int'(rs)) % (1 << hist(m));
        if (m_br[m] < smax(m)) m_br[m]++;
        if (pr != rs && m_mp[m] < smax(m)) m_mp[m]++;
    endtask

    task automatic drive(logic r, logic [31:0] p, logic u, int xa, int xb, logic pr, logic rs);
        rst = r; pc = p; upd = u; uia = 4'(xa); uib = 6'(xb); upd_pred = pr; res = rs;
    endtask

    // One clock: model follows the same edge, then return to the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) m_reset();
        else if (upd) begin
            m_update(0, int'(uia), upd_pred, res);
            m_update(1, int'(uib), upd_pred, res);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b1, 32'h0, 1'b0, 0, 0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        logic [31:0] p;
        drive(1'b1, 32'h0, 1'b1, 3, 3, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 6; i++) begin
            p = $urandom;
            drive(1'b0, p, 1'b0, 0, 0, 1'b0, 1'b0);
            #1;
            checks++; if (pa !== 1'b0) begin errors++; $display("FAIL reset_pred_a: got %0b expected 0", pa); end
            checks++; if (pb !== 1'b0) begin errors++; $display("FAIL reset_pred_b: got %0b expected 0", pb); end
            checks++; if (ib !== p[7:2]) begin errors++; $display("FAIL reset_idx_b: got %0h expected %0h", ib, p[7:2]); end
            tick();
        end
        checks++; if (bra !== 4'd0 || mpa !== 4'd0) begin errors++; $display("FAIL reset_stats_a: got %0d/%0d expected 0/0", bra, mpa); end
        checks++; if (brb !== 16'd0 || mpb !== 16'd0) begin errors++; $display("FAIL reset_stats_b: got %0d/%0d expected 0/0", brb, mpb); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h14, 1'b1, 5, 5, 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 32'h14, 1'b0, 0, 0, 1'b0, 1'b0);
        #1;
        checks++; if (ia !== 4'd5) begin errors++; $display("FAIL sat_idx: got %0h expected 5", ia); end
        checks++; if (pa !== 1'b1) begin errors++; $display("FAIL sat_taken: got %0b expected 1", pa); end
        // A fourth increment must not wrap; two decrements then cross the threshold.
        drive(1'b0, 32'h14, 1'b1, 5, 5, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h14, 1'b1, 5, 5, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h14, 1'b0, 0, 0, 1'b0, 1'b0);
        #1;
        checks++; if (pa !== 1'b1) begin errors++; $display("FAIL hyst_first_nt: got %0b expected 1", pa); end
        drive(1'b0, 32'h14, 1'b1, 5, 5, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h14, 1'b0, 0, 0, 1'b0, 1'b0);
        #1;
        checks++; if (pa !== 1'b0) begin errors++; $display("FAIL hyst_second_nt: got %0b expected 0", pa); end
    endtask

    task automatic test_gshare_index();
        logic [3:0] pattern;
        do_reset();
        pattern = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            drive(1'b0, 32'h0, 1'b1, $urandom, $urandom, 1'b0, pattern[i]);
            tick();
        end
        drive(1'b0, 32'h40, 1'b0, 0, 0, 1'b0, 1'b0);
        #1;
        checks++; if (ib !== 6'h1B) begin errors++; $display("FAIL gshare_idx: got %0h expected 1b", ib); end
        checks++; if (ia !== 4'h0) begin errors++; $display("FAIL bimodal_idx: got %0h expected 0", ia); end
        checks++; if (pb !== m_pred(1, pc)) begin errors++; $display("FAIL gshare_pred: got %0b expected %0b", pb, m_pred(1, pc)); end
    endtask

    task automatic test_collision();
        do_reset();
        drive(1'b0, 32'h20, 1'b1, 8, 8, 1'b0, 1'b1);
        #1;
        checks++; if (pa !== 1'b0) begin errors++; $display("FAIL collide_old: got %0b expected 0", pa); end
        tick();
        drive(1'b0, 32'h20, 1'b0, 0, 0, 1'b0, 1'b0);
        #1;
        checks++; if (pa !== 1'b1) begin errors++; $display("FAIL collide_new: got %0b expected 1", pa); end
    endtask

    task automatic test_stats();
        logic rs;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            rs = 1'($urandom);
            drive(1'b0, $urandom, 1'b1, $urandom, $urandom,
                  (i == 2 || i == 5 || i == 7) ? ~rs : rs, rs);
            tick();
            if (i == 9) begin
                checks++; if (bra !== 4'd10 || mpa !== 4'd3) begin errors++; $display("FAIL stats10_a: got %0d/%0d expected 10/3", bra, mpa); end
                checks++; if (brb !== 16'd10 || mpb !== 16'd3) begin errors++; $display("FAIL stats10_b: got %0d/%0d expected 10/3", brb, mpb); end
            end
        end
        checks++; if (bra !== 4'd15 || mpa !== 4'd3) begin errors++; $display("FAIL stats20_a_sat: got %0d/%0d expected 15/3", bra, mpa); end
        checks++; if (brb !== 16'd20 || mpb !== 16'd3) begin errors++; $display("FAIL stats20_b: got %0d/%0d expected 20/3", brb, mpb); end
    endtask

    task automatic test_midrun_reset();
        logic [31:0] p;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, $urandom, 1'b1, $urandom, $urandom, 1'($urandom), 1'b1);
            tick();
        end
        drive(1'b1, $urandom, 1'b1, 5, 5, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 6; i++) begin
            p = $urandom;
            drive(1'b0, p, 1'b0, 0, 0, 1'b0, 1'b0);
            #1;
            checks++; if (pa !== 1'b0 || pb !== 1'b0) begin errors++; $display("FAIL midrst_pred: got %0b/%0b expected 0/0", pa, pb); end
            checks++; if (ib !== p[7:2]) begin errors++; $display("FAIL midrst_ghr: got idx %0h expected %0h", ib, p[7:2]); end
            tick();
        end
        checks++; if (bra !== 4'd0 || brb !== 16'd0 || mpa !== 4'd0 || mpb !== 16'd0) begin
            errors++; $display("FAIL midrst_stats: got %0d/%0d/%0d/%0d expected 0", bra, mpa, brb, mpb);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 50) == 0, $urandom, 1'($urandom), $urandom, $urandom,
                  1'($urandom), 1'($urandom));
            #1;
            checks++; if (pa !== m_pred(0, pc) || ia !== 4'(m_idx(0, pc))) begin
                errors++; $display("FAIL rand_a: got %0b/%0h expected %0b/%0h", pa, ia, m_pred(0, pc), m_idx(0, pc));
            end
            checks++; if (pb !== m_pred(1, pc) || ib !== 6'(m_idx(1, pc))) begin
                errors++; $display("FAIL rand_b: got %0b/%0h expected %0b/%0h", pb, ib, m_pred(1, pc), m_idx(1, pc));
            end
            tick();
            checks++; if (bra !== 4'(m_br[0]) || mpa !== 4'(m_mp[0]) || brb !== 16'(m_br[1]) || mpb !== 16'(m_mp[1])) begin
                errors++; $display("FAIL rand_stats: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                                   bra, mpa, brb, mpb, m_br[0], m_mp[0], m_br[1], m_mp[1]);
            end
        end
    endtask

    initial begin
        drive(1'b1, 32'h0, 1'b0, 0, 0, 1'b0, 1'b0);
        m_reset();
        @(negedge clk);
        test_reset();
        test_saturation();
        test_gshare_index();
        test_collision();
        test_stats();
        test_midrun_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 Parameter ENTRIES, default 64, meaning pattern-table depth; power of two, 4..1024; IDX_W = log2(ENTRIES).
REQ-002 Parameter CTR_W, default 2, meaning saturating-counter width; 1..4.
REQ-003 Parameter HIST_W, default 4, meaning global-history length; 0..IDX_W; 0 selects bimodal mode, with no history.
REQ-004 Parameter STAT_W, default 16, meaning width of each statistics counter.
REQ-005 One clock, clk_i; reset rst_i is synchronous and active-high.
REQ-006 clk_i  input  1  clock; all state changes on the rising edge.
REQ-007 rst_i  input  1  synchronous active-high reset.
REQ-008 lookup_pc_i  input  32  PC of the branch being predicted, from the ID stage.
REQ-009 predict_o  output  1  predicted direction (1 = taken); combinational from lookup_pc_i and state.
REQ-010 predict_idx_o  output  IDX_W  table index used for predict_o; the pipeline carries it to EX.
REQ-011 update_i  input  1  a resolved branch is present in EX this cycle.
REQ-012 update_idx_i  input  IDX_W  index returned by predict_idx_o when this branch was predicted.
REQ-013 update_pred_i  input  1  the prediction originally made for this branch.
REQ-014 result_i  input  1  actual outcome (1 = taken).
REQ-015 stat_branches_o  output  STAT_W  count of resolved branches.
REQ-016 stat_mispred_o  output  STAT_W  count of mispredicted branches.

Function
REQ-017 The block SHALL hold ENTRIES counters of CTR_W bits each, plus one HIST_W-bit global history register (GHR).
REQ-018 The index SHALL be lookup_pc_i[IDX_W+1:2] XOR the GHR zero-extended to IDX_W bits; for HIST_W=0 it SHALL be lookup_pc_i[IDX_W+1:2].
REQ-019 predict_o SHALL be the MSB of the counter at the index, with zero-cycle latency; the pipeline holds no valid qualifier.
REQ-020 On update_i=1, the counter at update_idx_i SHALL increment if result_i=1 and decrement if result_i=0.
REQ-021 A counter SHALL saturate at 0 and at 2^CTR_W-1; it never wraps.
REQ-022 On update_i=1 with HIST_W>0, the GHR SHALL shift left with result_i entering at bit 0; the oldest bit is discarded.
REQ-023 The GHR SHALL update only at resolve time; there is no speculative history and no repair logic.
REQ-024 A lookup in the same cycle as an update SHALL see pre-edge state for both the counter and the GHR; there is no bypass, including when the lookup index equals update_idx_i.
REQ-025 On update_i=1, stat_branches_o SHALL increment by 1, and stat_mispred_o SHALL increment by 1 when update_pred_i != result_i.
REQ-026 Both statistics counters SHALL saturate at 2^STAT_W-1.
REQ-027 With update_i=0, no state SHALL change.

Reset
REQ-028 While rst_i=1 at a clock edge, every counter SHALL load 2^(CTR_W-1)-1 (weakly not-taken; for CTR_W=1 this is 0).
REQ-029 While rst_i=1 at a clock edge, the GHR SHALL load 0 and both statistics outputs SHALL load 0.
REQ-030 When rst_i=1 and update_i=1 coincide, reset SHALL win and the update is dropped.
REQ-031 Reset SHALL complete in one cycle, so predict_o=0 for any PC in the first cycle after rst_i falls.
REQ-032 Reset asserted mid-run SHALL discard all training.

Verification
REQ-033 Saturation, ENTRIES=16, CTR_W=2, HIST_W=0: after reset, 3 updates at idx 5 with result_i=1 -> predict_o=1 at PC 0x14; the counter stays at 3.
REQ-034 Hysteresis, ENTRIES=16, CTR_W=2, HIST_W=0: after REQ-033, 1 update with result_i=0 -> predict_o stays 1; a 2nd update with result_i=0 -> predict_o=0.
REQ-035 Gshare indexing, HIST_W=4: updates with result_i=1,0,1,1 set GHR=4'b1011; lookup_pc_i=0x40 -> predict_idx_o=0x10^0xB=0x1B for ENTRIES=64.
REQ-036 Same-index collision: lookup and update to the same index in one cycle -> predict_o shows the old value that cycle and the new value the next cycle.
REQ-037 Statistics: 10 updates with 3 mismatches -> stat_branches_o=10 and stat_mispred_o=3; with STAT_W=4 and 20 updates -> stat_branches_o=15.
REQ-038 Reset mid-run: rst_i=1 for one cycle together with update_i=1 -> all predictions 0, GHR=0 and statistics 0, with no residue from the dropped update.
